pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset; it SHALL be word-aligned.
REQ-002 Parameter PC_STEP, default 4, is the byte increment per sequential instruction.
REQ-003 Port Clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port Rst, input, 1, is a synchronous, active-low reset.
REQ-005 Port Start, input, 1, is a one-cycle request to leave IDLE and begin sequencing.
REQ-006 Port Stall, input, 1, holds PC while high.
REQ-007 Port Halt, input, 1, moves to HALTED.
REQ-008 Port LoadEn, input, 1, requests a jump to the instruction number on TargetNum.
REQ-009 Port TargetNum, input, 32, is a 1-based instruction number (cycle number) to jump to.
REQ-010 Port PCOut, output, 32, is the current byte address.
REQ-011 Port InstrNum, output, 32, is the registered value PCOut/4+1, kept consistent with PCOut every cycle.
REQ-012 Port CycleCount, output, 32, counts clock cycles spent in RUN.
REQ-013 Port Running, output, 1, is high in RUN.
REQ-014 Port Halted, output, 1, is high in HALTED.
REQ-015 Port BadTarget, output, 1, is a one-cycle pulse when a load is rejected.

Function
REQ-016 The state machine SHALL have three states: IDLE, RUN and HALTED.
- IDLE -> RUN on Start.
- RUN -> HALTED on Halt.
- HALTED -> IDLE on Start.
- No other transitions.
REQ-017 In RUN, per-cycle priority SHALL be Halt > LoadEn > Stall > increment.
- Increment: PCOut += PC_STEP; InstrNum += 1.
REQ-018 A load SHALL set PCOut = (TargetNum-1)*4 and InstrNum = TargetNum, both visible on the cycle after LoadEn (latency 1).
REQ-019 TargetNum = 0 or TargetNum > 32'h4000_0000 SHALL be rejected:
- PC and InstrNum follow the Stall/increment rule as if LoadEn were low.
- BadTarget pulses high for exactly one cycle.
REQ-020 Stall SHALL hold PCOut and InstrNum unchanged; CycleCount still increments.
REQ-021 On the cycle Halt is sampled, PCOut and InstrNum SHALL hold, and CycleCount SHALL increment for that cycle.
REQ-022 PCOut SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000, with InstrNum wrapping from 32'h4000_0000 to 1.
REQ-023 CycleCount SHALL wrap modulo 2^32 without saturating.
REQ-024 In IDLE and HALTED:
- PC and InstrNum are frozen.
- Stall, LoadEn and Halt are ignored; BadTarget stays 0.
REQ-025 When leaving HALTED for IDLE, PCOut, InstrNum and CycleCount SHALL keep their values (resume semantics); only reset clears them.
REQ-026 Running and Halted SHALL be registered decodes of the state and never both high.

Reset
REQ-027 When Rst = 0 at a rising edge, the block SHALL set:
- state = IDLE
- PCOut = RESET_PC
- InstrNum = RESET_PC/4+1
- CycleCount = 0
- Running = 0, Halted = 0, BadTarget = 0
REQ-028 Reset asserted mid-RUN, including during a simultaneous LoadEn or Halt, SHALL override all other inputs in that cycle.

Structure
REQ-029 Package pc_seq_pkg SHALL hold:
- the state enum (IDLE, RUN, HALTED)
- PC_STEP
- the maximum valid TargetNum constant 32'h4000_0000
REQ-030 The TargetNum-to-PC conversion and range check SHALL be one combinational sub-module, num_to_pc (inverse of the PC-to-cycle-number mapping), instantiated once.

Verification
REQ-031 Reset, Start, 3 free cycles -> PCOut 0,4,8,12; InstrNum 1,2,3,4; CycleCount 3; Running = 1.
REQ-032 In RUN, LoadEn with TargetNum = 10 and Stall = 1 simultaneously -> next cycle PCOut = 36, InstrNum = 10; next free cycle PCOut = 40.
REQ-033 LoadEn with TargetNum = 0, then TargetNum = 32'h4000_0001 -> BadTarget pulses once each, PC increments normally, no jump.
REQ-034 Load TargetNum = 32'h4000_0000, one free cycle -> PCOut 32'hFFFF_FFFC then 0; InstrNum 32'h4000_0000 then 1.
REQ-035 Halt together with LoadEn at PCOut = 20 -> Halted = 1, PCOut stays 20; Start -> IDLE; Start -> RUN resuming at 24.
REQ-036 Rst = 0 during LoadEn with TargetNum = 5 in RUN -> next cycle PCOut = 0, InstrNum = 1, CycleCount = 0, state IDLE.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  // Default byte increment per sequential instruction.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Largest instruction number that maps onto a 32-bit word address.
  localparam logic [31:0] MAX_TARGET = 32'h4000_0000;

endpackage : pc_seq_pkg

// File: rtl/num_to_pc.sv
// Converts a 1-based instruction number into a word byte address and
// flags whether that number lies inside the addressable range.
module num_to_pc
  import pc_seq_pkg::*;
(
  input  logic [31:0] target_num_i,
  output logic [31:0] target_pc_o,
  output logic        target_ok_o
);

  // Inverse of instr = pc/4 + 1; numbers 0 and above MAX_TARGET are rejected.
  always_comb begin
    target_pc_o = (target_num_i - 32'd1) << 2;
    target_ok_o = (target_num_i != 32'd0) && (target_num_i <= MAX_TARGET);
  end

endmodule : num_to_pc

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED control with stall, jump to
// instruction number, run-cycle counting and a rejected-jump pulse.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,  // must be word-aligned
  parameter logic [31:0] PC_STEP  = pc_seq_pkg::PC_STEP
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        LoadEn,
  input  logic [31:0] TargetNum,
  output logic [31:0] PCOut,
  output logic [31:0] InstrNum,
  output logic [31:0] CycleCount,
  output logic        Running,
  output logic        Halted,
  output logic        BadTarget
);

  import pc_seq_pkg::*;

  localparam logic [31:0] RESET_INSTR = (RESET_PC >> 2) + 32'd1;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] cycle_q;
  logic        running_q;
  logic        halted_q;
  logic        bad_q;

  logic [31:0] pc_inc_d;
  logic [31:0] instr_inc_d;
  logic [31:0] target_pc;
  logic        target_ok;

  num_to_pc u_num_to_pc (
    .target_num_i (TargetNum),
    .target_pc_o  (target_pc),
    .target_ok_o  (target_ok)
  );

  // Sequential successors; InstrNum wraps to 1 together with the PC wrap to 0.
  always_comb begin
    pc_inc_d    = pc_q + PC_STEP;
    instr_inc_d = (instr_q == MAX_TARGET) ? 32'd1 : instr_q + 32'd1;
  end

  // Control FSM with PC, counter and registered status outputs.
  // NOTE: every register here uses <= so all of them see pre-edge values of each other.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= RESET_INSTR;
      cycle_q   <= 32'd0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      bad_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          cycle_q <= cycle_q + 32'd1;
          if (Halt) begin
            state_q   <= HALTED;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end else if (LoadEn && target_ok) begin
            pc_q    <= target_pc;
            instr_q <= TargetNum;
          end else begin
            // A rejected load falls through to the stall/increment rule.
            if (LoadEn) bad_q <= 1'b1;
            if (!Stall) begin
              pc_q    <= pc_inc_d;
              instr_q <= instr_inc_d;
            end
          end
        end
        HALTED: begin
          // Resume semantics: PC and counters are left untouched.
          if (Start) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PCOut      = pc_q;
  assign InstrNum   = instr_q;
  assign CycleCount = cycle_q;
  assign Running    = running_q;
  assign Halted     = halted_q;
  assign BadTarget  = bad_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic        Stall;
  logic        Halt;
  logic        LoadEn;
  logic [31:0] TargetNum;
  logic [31:0] PCOut;
  logic [31:0] InstrNum;
  logic [31:0] CycleCount;
  logic        Running;
  logic        Halted;
  logic        BadTarget;

  int vectors     = 0;
  int miscompares = 0;

  pc_sequencer dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Stall      (Stall),
    .Halt       (Halt),
    .LoadEn     (LoadEn),
    .TargetNum  (TargetNum),
    .PCOut      (PCOut),
    .InstrNum   (InstrNum),
    .CycleCount (CycleCount),
    .Running    (Running),
    .Halted     (Halted),
    .BadTarget  (BadTarget)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; returns on the following falling edge for sampling/driving.
  task automatic step();
    @(negedge Clk);
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] cyc, input logic run, input logic hlt,
                           input logic bad);
    check({tag, ".pc"},    PCOut,       pc);
    check({tag, ".instr"}, InstrNum,    ins);
    check({tag, ".cycle"}, CycleCount,  cyc);
    check({tag, ".run"},   {31'd0, Running},   {31'd0, run});
    check({tag, ".halt"},  {31'd0, Halted},    {31'd0, hlt});
    check({tag, ".bad"},   {31'd0, BadTarget}, {31'd0, bad});
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Stall = 1'b0; Halt = 1'b0; LoadEn = 1'b0; TargetNum = 32'd0;
    step(); step();
    check_all("reset", 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);

    Rst = 1'b1;
    step();
    check_all("idle", 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);

    Start = 1'b1;
    step();
    Start = 1'b0;
    check_all("start", 32'd0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    step(); check_all("free1", 32'd4,  32'd2, 32'd1, 1'b1, 1'b0, 1'b0);
    step(); check_all("free2", 32'd8,  32'd3, 32'd2, 1'b1, 1'b0, 1'b0);
    step(); check_all("free3", 32'd12, 32'd4, 32'd3, 1'b1, 1'b0, 1'b0);

    // Load beats stall.
    LoadEn = 1'b1; TargetNum = 32'd10; Stall = 1'b1;
    step();
    LoadEn = 1'b0; Stall = 1'b0;
    check_all("load10", 32'd36, 32'd10, 32'd4, 1'b1, 1'b0, 1'b0);
    step(); check_all("after_load", 32'd40, 32'd11, 32'd5, 1'b1, 1'b0, 1'b0);

    Stall = 1'b1;
    step();
    Stall = 1'b0;
    check_all("stall", 32'd40, 32'd11, 32'd6, 1'b1, 1'b0, 1'b0);

    // Rejected targets increment normally and pulse BadTarget.
    LoadEn = 1'b1; TargetNum = 32'd0;
    step(); check_all("bad_zero", 32'd44, 32'd12, 32'd7, 1'b1, 1'b0, 1'b1);
    TargetNum = 32'h4000_0001;
    step(); check_all("bad_high", 32'd48, 32'd13, 32'd8, 1'b1, 1'b0, 1'b1);
    LoadEn = 1'b0;
    step(); check_all("bad_clear", 32'd52, 32'd14, 32'd9, 1'b1, 1'b0, 1'b0);

    // Highest valid target and the wrap that follows.
    LoadEn = 1'b1; TargetNum = 32'h4000_0000;
    step();
    LoadEn = 1'b0;
    check_all("load_max", 32'hFFFF_FFFC, 32'h4000_0000, 32'd10, 1'b1, 1'b0, 1'b0);
    step(); check_all("wrap", 32'd0, 32'd1, 32'd11, 1'b1, 1'b0, 1'b0);

    LoadEn = 1'b1; TargetNum = 32'd5;
    step();
    LoadEn = 1'b0;
    check_all("load5", 32'd16, 32'd5, 32'd12, 1'b1, 1'b0, 1'b0);
    step(); check_all("pc20", 32'd20, 32'd6, 32'd13, 1'b1, 1'b0, 1'b0);

    // Halt beats load; the halt cycle is still counted.
    Halt = 1'b1; LoadEn = 1'b1; TargetNum = 32'd10;
    step();
    check_all("halt", 32'd20, 32'd6, 32'd14, 1'b0, 1'b1, 1'b0);
    Stall = 1'b1; TargetNum = 32'd0;
    step();
    Halt = 1'b0; LoadEn = 1'b0; Stall = 1'b0;
    check_all("halted_ignore", 32'd20, 32'd6, 32'd14, 1'b0, 1'b1, 1'b0);

    Start = 1'b1;
    step();
    Start = 1'b0;
    check_all("to_idle", 32'd20, 32'd6, 32'd14, 1'b0, 1'b0, 1'b0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_all("resume", 32'd20, 32'd6, 32'd14, 1'b1, 1'b0, 1'b0);
    step(); check_all("resume_inc", 32'd24, 32'd7, 32'd15, 1'b1, 1'b0, 1'b0);

    // Reset overrides a simultaneous load.
    Rst = 1'b0; LoadEn = 1'b1; TargetNum = 32'd5;
    step();
    check_all("rst_load", 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1; TargetNum = 32'd0;
    step();
    LoadEn = 1'b0;
    check_all("idle_ignore", 32'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_sequencer
